// File: rtl/psum_pkg.sv
// Shared types and sizing helpers for the partial-sum accumulation controller.
package psum_pkg;

   // Controller states
   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StOut,
      StDone
   } psum_state_e;

   // Raw code width per channel and decoded signed value width
   localparam int unsigned CodeW = 5;
   localparam int unsigned DecW  = 4;

   // Accumulator wide enough for MACRO_NUM*PASS_NUM worst-case decoded values
   function automatic int unsigned acc_width(input int unsigned macro_num,
                                             input int unsigned pass_num);
      return DecW + $clog2(macro_num * pass_num);
   endfunction

   // Index register width that stays legal when the count is 1
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psum_code_lut.sv
// Decodes one 5-bit partial-sum code into a signed 4-bit value:
// v = -8 + k[1:0] + 3*k[2] + 4*k[3] + 5*k[4], range -8..7.
module psum_code_lut
   import psum_pkg::*;
(
   input  logic [CodeW-1:0]       code_i,
   output logic signed [DecW-1:0] val_o
);

   logic [DecW-1:0] mag;

   // Positive weight sum is at most 15, so subtracting 8 in 4 bits lands in -8..7
   always_comb begin
      mag   = {2'b00, code_i[1:0]}
            + (code_i[2] ? 4'd3 : 4'd0)
            + (code_i[3] ? 4'd4 : 4'd0)
            + (code_i[4] ? 4'd5 : 4'd0);
      val_o = $signed(mag - 4'd8);
   end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Sequences MACRO_NUM macros over PASS_NUM passes, accumulates decoded per-channel
// partial sums, then presents the reduced result vector with a valid/ready handoff.
// Optional feature macro: PSUM_ACCUM_SAT_EN (saturate results to OUT_W instead of wrapping).
module psum_accum_ctrl
   import psum_pkg::*;
#(
   parameter int unsigned CHANNEL_NUM = 128,
   parameter int unsigned MACRO_NUM   = 4,
   parameter int unsigned PASS_NUM    = 2,
   parameter int unsigned OUT_W       = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_i,
   output logic                           busy_o,
   output logic                           mac_req_o,
   output logic [MACRO_NUM-1:0]           mac_sel_o,
   input  logic                           mac_valid_i,
   input  logic [CodeW*CHANNEL_NUM-1:0]   mac_code_i,
   output logic                           acc_valid_o,
   input  logic                           acc_ready_i,
   output logic [OUT_W*CHANNEL_NUM-1:0]   acc_data_o,
   output logic                           done_o
);

   localparam int unsigned AccW     = acc_width(MACRO_NUM, PASS_NUM);
   localparam int unsigned MacIdxW  = idx_width(MACRO_NUM);
   localparam int unsigned PassIdxW = idx_width(PASS_NUM);
   localparam logic [MacIdxW-1:0]  MacLast  = MacIdxW'(MACRO_NUM - 1);
   localparam logic [PassIdxW-1:0] PassLast = PassIdxW'(PASS_NUM - 1);

   psum_state_e          state_q, state_d;
   logic [MacIdxW-1:0]   mac_idx_q, mac_idx_d;
   logic [PassIdxW-1:0]  pass_idx_q, pass_idx_d;
   logic signed [AccW-1:0] acc_q [CHANNEL_NUM];
   logic signed [AccW-1:0] acc_d [CHANNEL_NUM];

   logic acc_clr;
   logic acc_add;

   logic [CHANNEL_NUM-1:0][DecW-1:0]  dec_val;
   logic [CHANNEL_NUM-1:0][OUT_W-1:0] red;

   // Per-channel decode and accumulator-to-output reduction
   for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_chan
      psum_code_lut u_lut (
         .code_i (mac_code_i[CodeW*c +: CodeW]),
         .val_o  (dec_val[c])
      );

`ifdef PSUM_ACCUM_SAT_EN
      if (OUT_W < AccW) begin : g_sat
         localparam int SatMaxI = (1 << (OUT_W - 1)) - 1;
         localparam logic signed [AccW-1:0] SatMax = AccW'(SatMaxI);
         localparam logic signed [AccW-1:0] SatMin = AccW'(-SatMaxI - 1);
         logic signed [AccW-1:0] clamped;
         assign clamped = (acc_q[c] > SatMax) ? SatMax :
                          (acc_q[c] < SatMin) ? SatMin : acc_q[c];
         assign red[c]  = OUT_W'(clamped);
      end else begin : g_ext
         assign red[c] = OUT_W'(acc_q[c]);
      end
`else
      // Signed cast truncates (wrap) or sign-extends as the widths require
      assign red[c] = OUT_W'(acc_q[c]);
`endif
   end

   // FSM next-state, index sequencing and Moore outputs
   always_comb begin
      state_d     = state_q;
      mac_idx_d   = mac_idx_q;
      pass_idx_d  = pass_idx_q;
      acc_clr     = 1'b0;
      acc_add     = 1'b0;
      mac_req_o   = 1'b0;
      mac_sel_o   = '0;
      acc_valid_o = 1'b0;
      done_o      = 1'b0;
      busy_o      = (state_q != StIdle);

      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d    = StRead;
               mac_idx_d  = '0;
               pass_idx_d = '0;
               acc_clr    = 1'b1;
            end
         end
         StRead: begin
            mac_req_o = 1'b1;
            mac_sel_o = MACRO_NUM'(1) << mac_idx_q;
            if (mac_valid_i) begin
               acc_add = 1'b1;
               if (mac_idx_q == MacLast) begin
                  mac_idx_d = '0;
                  if (pass_idx_q == PassLast) begin
                     pass_idx_d = '0;
                     state_d    = StOut;
                  end else begin
                     pass_idx_d = pass_idx_q + PassIdxW'(1);
                  end
               end else begin
                  mac_idx_d = mac_idx_q + MacIdxW'(1);
               end
            end
         end
         StOut: begin
            acc_valid_o = 1'b1;
            if (acc_ready_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Accumulator next-state: clear at job start, add decoded value on each beat
   always_comb begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         acc_d[c] = acc_q[c];
         if (acc_clr) begin
            acc_d[c] = '0;
         end else if (acc_add) begin
            acc_d[c] = acc_q[c] + AccW'($signed(dec_val[c]));
         end
      end
   end

   // Result bus is only driven while the vector is offered
   always_comb begin
      acc_data_o = '0;
      if (state_q == StOut) begin
         acc_data_o = red;
      end
   end

   // State, index and accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         mac_idx_q  <= '0;
         pass_idx_q <= '0;
         for (int c = 0; c < CHANNEL_NUM; c++) begin
            acc_q[c] <= '0;
         end
      end else begin
         state_q    <= state_d;
         mac_idx_q  <= mac_idx_d;
         pass_idx_q <= pass_idx_d;
         for (int c = 0; c < CHANNEL_NUM; c++) begin
            acc_q[c] <= acc_d[c];
         end
      end
   end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench: two instances (OUT_W=8 and OUT_W=6) share all inputs, 4 channels,
// 4 macros, 2 passes; expected vectors are hand-computed from the code decode.
module tb_psum_accum_ctrl;

   localparam int unsigned CH = 4;
   localparam int unsigned MN = 4;
   localparam int unsigned PN = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          mac_valid;
   logic [5*CH-1:0] mac_code;
   logic          acc_ready;

   logic          busy8, mac_req8, acc_valid8, done8;
   logic [MN-1:0] mac_sel8;
   logic [8*CH-1:0] data8;
   logic          busy6, mac_req6, acc_valid6, done6;
   logic [MN-1:0] mac_sel6;
   logic [6*CH-1:0] data6;

   int checks = 0;
   int errors = 0;

   psum_accum_ctrl #(
      .CHANNEL_NUM (CH),
      .MACRO_NUM   (MN),
      .PASS_NUM    (PN),
      .OUT_W       (8)
   ) u_dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .busy_o      (busy8),
      .mac_req_o   (mac_req8),
      .mac_sel_o   (mac_sel8),
      .mac_valid_i (mac_valid),
      .mac_code_i  (mac_code),
      .acc_valid_o (acc_valid8),
      .acc_ready_i (acc_ready),
      .acc_data_o  (data8),
      .done_o      (done8)
   );

   psum_accum_ctrl #(
      .CHANNEL_NUM (CH),
      .MACRO_NUM   (MN),
      .PASS_NUM    (PN),
      .OUT_W       (6)
   ) u_dut6 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .busy_o      (busy6),
      .mac_req_o   (mac_req6),
      .mac_sel_o   (mac_sel6),
      .mac_valid_i (mac_valid),
      .mac_code_i  (mac_code),
      .acc_valid_o (acc_valid6),
      .acc_ready_i (acc_ready),
      .acc_data_o  (data6),
      .done_o      (done6)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".busy"},  {busy6, busy8},         2'b00);
      check({tag, ".req"},   {mac_req6, mac_req8},   2'b00);
      check({tag, ".sel"},   {mac_sel6, mac_sel8},   8'h00);
      check({tag, ".valid"}, {acc_valid6, acc_valid8}, 2'b00);
      check({tag, ".done"},  {done6, done8},         2'b00);
      check({tag, ".data8"}, data8, 32'h0);
      check({tag, ".data6"}, data6, 24'h0);
   endtask

   function automatic logic [5*CH-1:0] all_codes(input logic [4:0] k);
      return {CH{k}};
   endfunction

   initial begin
      logic [MN-1:0] exp_sel;
      logic [31:0]   held;

      rst_n     = 1'b0;
      start     = 1'b0;
      mac_valid = 1'b0;
      mac_code  = '0;
      acc_ready = 1'b0;

      // Reset state
      #1;
      check_quiet("reset");
      step();
      step();
      rst_n = 1'b1;

      // Test 1: all codes -8, eight beats back-to-back, first start right after release
      mac_code  = all_codes(5'b00000);
      mac_valid = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      check("t1.busy", busy8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         exp_sel = MN'(1) << (i % 4);
         check($sformatf("t1.req%0d", i), mac_req8, 1'b1);
         check($sformatf("t1.sel%0d", i), mac_sel8, exp_sel);
         step();
      end
      check("t1.valid", acc_valid8, 1'b1);
      check("t1.req_off", mac_req8, 1'b0);
      check("t1.sel_off", mac_sel8, 4'h0);
      check("t1.data8", data8, 32'hC0C0C0C0);
`ifdef PSUM_ACCUM_SAT_EN
      check("t1.data6", data6, 24'h820820);
`else
      check("t1.data6", data6, 24'h000000);
`endif
      mac_valid = 1'b0;
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      check("t1.done", done8, 1'b1);
      check("t1.valid_off", acc_valid8, 1'b0);
      check("t1.busy_done", busy8, 1'b1);
      step();
      check("t1.done_off", done8, 1'b0);
      check("t1.idle", busy8, 1'b0);

      // Test 2: all codes +7 -> accumulator 56
      mac_code  = all_codes(5'b11111);
      mac_valid = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      check("t2.valid", acc_valid6, 1'b1);
      check("t2.data8", data8, 32'h38383838);
`ifdef PSUM_ACCUM_SAT_EN
      check("t2.data6", data6, 24'h7DF7DF);
`else
      check("t2.data6", data6, 24'hE38E38);
`endif
      mac_valid = 1'b0;
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      check("t2.done", done6, 1'b1);
      step();

      // Test 3: mixed codes (0, +3, -8, +7), mac_valid toggling
      mac_code = {5'b11111, 5'b00000, 5'b10111, 5'b01101};
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_sel   = MN'(1) << (i % 4);
         mac_valid = 1'b0;
         check($sformatf("t3.sel%0d", i), mac_sel8, exp_sel);
         step();
         check($sformatf("t3.hold%0d", i), mac_sel8, exp_sel);
         mac_valid = 1'b1;
         step();
      end
      mac_valid = 1'b0;
      check("t3.valid", acc_valid8, 1'b1);
      check("t3.data8", data8, 32'h38C01800);
`ifdef PSUM_ACCUM_SAT_EN
      check("t3.data6", data6, 24'h7E0600);
`else
      check("t3.data6", data6, 24'hE00600);
`endif

      // Test 4: back-pressure in OUT with start pulsed; data holds, start ignored
      held = data8;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         step();
         check($sformatf("t4.valid%0d", i), acc_valid8, 1'b1);
         check($sformatf("t4.data%0d", i), data8, 32'h38C01800);
         check($sformatf("t4.done%0d", i), done8, 1'b0);
      end
      start     = 1'b0;
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      check("t4.done", done8, 1'b1);
      step();
      check("t4.done_off", done8, 1'b0);
      check("t4.idle", busy8, 1'b0);
      check("t4.no_req", mac_req8, 1'b0);
      check("t4.held", held, 32'h38C01800);

      // Test 5: reset after three beats, then a fresh job
      mac_code  = all_codes(5'b11111);
      mac_valid = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("t5.sel3", mac_sel8, 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("t5.rst");
      mac_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("t5.no_done0", {done6, done8}, 2'b00);
      step();
      check("t5.no_done1", {done6, done8}, 2'b00);
      check("t5.idle", busy8, 1'b0);
      mac_code  = all_codes(5'b10111);
      mac_valid = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      check("t5.restart", busy8, 1'b1);
      repeat (8) step();
      check("t5.valid", acc_valid8, 1'b1);
      check("t5.data8", data8, 32'h18181818);
      check("t5.data6", data6, 24'h618618);
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      check("t5.done", done8, 1'b1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
